// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, TX FSM states and frame-size helpers.
// Used by both the TX framer and the baud generator.
package uart_pkg;

   localparam int unsigned OVS    = 8;
   localparam int unsigned DW_MIN = 5;
   localparam int unsigned DW_MAX = 9;

   localparam logic [2:0] PAR_NONE   = 3'b000;
   localparam logic [2:0] PAR_ODD    = 3'b001;
   localparam logic [2:0] PAR_EVEN   = 3'b010;
   localparam logic [2:0] PAR_STICK0 = 3'b100;
   localparam logic [2:0] PAR_STICK1 = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak,
      StBrkStop
   } tx_state_e;

   function automatic logic [3:0] clamp_dw(input logic [3:0] ds);
      if (ds < 4'(DW_MIN)) return 4'(DW_MIN);
      if (ds > 4'(DW_MAX)) return 4'(DW_MAX);
      return ds;
   endfunction

   // Reserved codes collapse to "no parity".
   function automatic logic [2:0] norm_parity(input logic [2:0] p);
      case (p)
         PAR_ODD, PAR_EVEN, PAR_STICK0, PAR_STICK1: return p;
         default:                                   return PAR_NONE;
      endcase
   endfunction

   function automatic logic parity_bit(input logic [2:0] mode, input logic acc);
      case (mode)
         PAR_ODD:    return ~acc;
         PAR_EVEN:   return acc;
         PAR_STICK1: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Payload handshake between the TX FIFO pop side (master) and the framer (slave).
interface uart_tx_framer_if #(
   parameter int unsigned MAX_DW = 9
);
   logic [MAX_DW-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud timing: prescale counter producing subticks, OVS subticks per bit time.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  subtick,
   output logic                  bit_tick
);

   localparam int unsigned SubW = $clog2(OVS);

   logic [PRESCALE_W-1:0] pr_cnt_q, pr_cnt_d;
   logic [SubW-1:0]       sub_cnt_q, sub_cnt_d;

   assign subtick  = ~clear & (pr_cnt_q == prescale);
   assign bit_tick = subtick & (sub_cnt_q == SubW'(OVS - 1));

   always_comb begin
      pr_cnt_d  = pr_cnt_q;
      sub_cnt_d = sub_cnt_q;
      if (clear) begin
         pr_cnt_d  = '0;
         sub_cnt_d = '0;
      end else if (subtick) begin
         pr_cnt_d  = '0;
         sub_cnt_d = sub_cnt_q + SubW'(1);
      end else begin
         pr_cnt_d  = pr_cnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pr_cnt_q  <= '0;
         sub_cnt_q <= '0;
      end else begin
         pr_cnt_q  <= pr_cnt_d;
         sub_cnt_q <= sub_cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 5-9 data bits LSB first, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the brk_req port and line-break generation.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 16,
   parameter int unsigned MAX_DW     = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [3:0]            data_size,
   input  logic                  stop2,
   input  logic [2:0]            parity,
   uart_tx_framer_if.slave       bus,
`ifdef UART_TX_BREAK_EN
   input  logic                  brk_req,
`endif
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   tx_state_e             state_q, state_d;
   logic                  tx_q, tx_d;
   logic [MAX_DW-1:0]     shift_q, shift_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  par_acc_q, par_acc_d;
   logic [PRESCALE_W-1:0] pr_q, pr_d;
   logic [3:0]            n_q, n_d;
   logic                  stop2_q, stop2_d;
   logic [2:0]            par_mode_q, par_mode_d;

   logic ready, accept, bit_tick, baud_clear, stop_last, data_last;
   logic baud_subtick_unused;
   logic brk_start, brk_hold;

`ifdef UART_TX_BREAK_EN
   assign brk_start = en & (state_q == StIdle) & brk_req;
   assign brk_hold  = (state_q == StBreak);
   assign ready     = en & (state_q == StIdle) & ~brk_req;
`else
   assign brk_start = 1'b0;
   assign brk_hold  = 1'b0;
   assign ready     = en & (state_q == StIdle);
`endif

   assign bus.tx_ready = ready;
   assign accept       = bus.tx_valid & ready;
   assign busy         = (state_q != StIdle);
   assign tx           = tx_q;
   assign stop_last    = ~stop2_q | (bit_cnt_q == 4'd1);
   assign data_last    = (bit_cnt_q == n_q - 4'd1);
   assign done         = en & (state_q == StStop) & bit_tick & stop_last;

   // Counters sit at zero whenever no bit time is being measured.
   assign baud_clear = ~en | (state_q == StIdle) | brk_hold;

   uart_baud_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (baud_clear),
      .prescale (pr_q),
      .subtick  (baud_subtick_unused),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      par_acc_d  = par_acc_q;
      pr_d       = pr_q;
      n_d        = n_q;
      stop2_d    = stop2_q;
      par_mode_d = par_mode_q;

      if (!en) begin
         state_d   = StIdle;
         tx_d      = 1'b1;
         bit_cnt_d = '0;
         par_acc_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (brk_start) begin
                  state_d = StBreak;
                  tx_d    = 1'b0;
                  pr_d    = prescale;
               end else if (accept) begin
                  state_d    = StStart;
                  tx_d       = 1'b0;
                  shift_d    = bus.tx_data;
                  pr_d       = prescale;
                  n_d        = clamp_dw(data_size);
                  stop2_d    = stop2;
                  par_mode_d = norm_parity(parity);
                  bit_cnt_d  = '0;
                  par_acc_d  = 1'b0;
               end
            end
            StStart: begin
               if (bit_tick) begin
                  state_d = StData;
                  tx_d    = shift_q[0];
               end
            end
            StData: begin
               if (bit_tick) begin
                  par_acc_d = par_acc_q ^ shift_q[0];
                  shift_d   = shift_q >> 1;
                  if (data_last) begin
                     bit_cnt_d = '0;
                     if (par_mode_q != PAR_NONE) begin
                        state_d = StParity;
                        tx_d    = parity_bit(par_mode_q, par_acc_q ^ shift_q[0]);
                     end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                     tx_d      = shift_q[1];
                  end
               end
            end
            StParity: begin
               if (bit_tick) begin
                  state_d   = StStop;
                  tx_d      = 1'b1;
                  bit_cnt_d = '0;
               end
            end
            StStop: begin
               if (bit_tick) begin
                  if (stop_last) begin
                     state_d   = StIdle;
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
               if (!brk_req) begin
                  state_d = StBrkStop;
                  tx_d    = 1'b1;
               end
            end
            StBrkStop: begin
               if (bit_tick) state_d = StIdle;
            end
`endif
            default: begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         tx_q       <= 1'b1;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_acc_q  <= 1'b0;
         pr_q       <= '0;
         n_q        <= '0;
         stop2_q    <= 1'b0;
         par_mode_q <= PAR_NONE;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_acc_q  <= par_acc_d;
         pr_q       <= pr_d;
         n_q        <= n_d;
         stop2_q    <= stop2_d;
         par_mode_q <= par_mode_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame bit patterns, parity, back-to-back, abort, reset.
// Break generation is exercised when UART_TX_BREAK_EN is defined.
module tb_uart_tx_framer;

   logic        clk = 1'b0;
   logic        rst, en, stop2;
   logic [15:0] prescale;
   logic [3:0]  data_size;
   logic [2:0]  parity;
   logic        tx, busy, done;
`ifdef UART_TX_BREAK_EN
   logic        brk_req;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   uart_tx_framer_if #(.MAX_DW(9)) bus ();

   uart_tx_framer #(
      .PRESCALE_W (16),
      .MAX_DW     (9)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .prescale  (prescale),
      .data_size (data_size),
      .stop2     (stop2),
      .parity    (parity),
      .bus       (bus),
`ifdef UART_TX_BREAK_EN
      .brk_req   (brk_req),
`endif
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_cfg(input int pr, input int ds, input logic s2, input logic [2:0] par);
      prescale  = 16'(pr);
      data_size = 4'(ds);
      stop2     = s2;
      parity    = par;
   endtask

   // Raise valid, wait (bounded) for ready, return just after the accepting edge.
   task automatic accept(input string tag, input logic [8:0] data, output int waited);
      waited       = 0;
      bus.tx_data  = data;
      bus.tx_valid = 1'b1;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.tx_ready && waited < 5000);
      check({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // bits: expected line level per bit time, in transmit order.
   task automatic watch_frame(input string tag, input string bits, input int bclk);
      int total;
      bit early;
      total = bits.len() * bclk;
      early = 1'b0;
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         if (k == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
         if (k % bclk == bclk / 2)
            check($sformatf("%s_bit%0d", tag, k / bclk), 32'(tx), 32'(bits[k / bclk] == "1"));
         if (k < total && done) early = 1'b1;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_early_done"}, 32'(early), 32'd0);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, "_idle_ready"}, 32'(bus.tx_ready), 32'd1);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_tx"}, 32'(tx), 32'd1);
   endtask

   initial begin
      int w;
      rst          = 1'b1;
      en           = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
`ifdef UART_TX_BREAK_EN
      brk_req      = 1'b0;
`endif
      set_cfg(10, 8, 1'b0, 3'b000);
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready_en0", 32'(bus.tx_ready), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clk);
      check("en_ready", 32'(bus.tx_ready), 32'd1);

      // 8N1 0xA5 at PR=10; inputs scrambled after accept must be ignored
      set_cfg(10, 8, 1'b0, 3'b000);
      accept("a5", 9'h0A5, w);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 9'h000;
      set_cfg(3, 5, 1'b1, 3'b001);
      watch_frame("a5", "0101001011", 88);
      idle_check("a5");

      // stick-1, 2 stop, back-to-back 0xC3 then 0x91 with valid held
      set_cfg(21, 8, 1'b1, 3'b101);
      accept("c3", 9'h0C3, w);
      bus.tx_data = 9'h091;
      watch_frame("c3", "011000011111", 176);
      accept("91s", 9'h091, w);
      check("b2b_gap", 32'(w), 32'd1);
      bus.tx_valid = 1'b0;
      watch_frame("91s", "010001001111", 176);
      idle_check("91s");

      // PR=0 parity cases
      set_cfg(0, 7, 1'b0, 3'b010);
      accept("55e", 9'h055, w);
      bus.tx_valid = 1'b0;
      watch_frame("55e", "0101010101", 8);
      set_cfg(0, 8, 1'b0, 3'b010);
      accept("91e", 9'h091, w);
      bus.tx_valid = 1'b0;
      watch_frame("91e", "01000100111", 8);
      set_cfg(0, 5, 1'b0, 3'b001);
      accept("13o", 9'h013, w);
      bus.tx_valid = 1'b0;
      watch_frame("13o", "01100101", 8);
      // data_size 12 clamps to 9; reserved parity 011 means none
      set_cfg(0, 12, 1'b0, 3'b011);
      accept("1a5", 9'h1A5, w);
      bus.tx_valid = 1'b0;
      watch_frame("1a5", "01010010111", 8);
      idle_check("1a5");

      // en dropped mid-DATA
      set_cfg(10, 8, 1'b0, 3'b000);
      accept("abort", 9'h0A5, w);
      bus.tx_valid = 1'b0;
      repeat (200) @(negedge clk);
      check("abort_pre_tx", 32'(tx), 32'd0);
      en = 1'b0;
      @(negedge clk);
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ready", 32'(bus.tx_ready), 32'd0);
      en = 1'b1;
      accept("reA5", 9'h0A5, w);
      bus.tx_valid = 1'b0;
      watch_frame("reA5", "0101001011", 88);
      idle_check("reA5");

      // rst mid-frame, then data_size 3 sends 5 bits
      accept("rstf", 9'h0A5, w);
      bus.tx_valid = 1'b0;
      repeat (300) @(negedge clk);
      rst       = 1'b1;
      data_size = 4'd3;
      @(negedge clk);
      check("midrst_tx", 32'(tx), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      set_cfg(0, 3, 1'b0, 3'b000);
      accept("ds3", 9'h1F6, w);
      bus.tx_valid = 1'b0;
      watch_frame("ds3", "0011011", 8);
      idle_check("ds3");

`ifdef UART_TX_BREAK_EN
      begin
         bit brk_done;
         brk_done = 1'b0;
         prescale = 16'd10;
         brk_req  = 1'b1;
         for (int k = 1; k <= 1089; k++) begin
            @(negedge clk);
            if (done) brk_done = 1'b1;
            if (k == 1) begin
               check("brk_tx_low", 32'(tx), 32'd0);
               check("brk_ready", 32'(bus.tx_ready), 32'd0);
            end
            if (k == 1000) begin
               check("brk_tx_end", 32'(tx), 32'd0);
               brk_req = 1'b0;
            end
            if (k == 1001) check("brk_stop_tx", 32'(tx), 32'd1);
            if (k == 1088) check("brk_stop_ready", 32'(bus.tx_ready), 32'd0);
            if (k == 1089) check("brk_idle_ready", 32'(bus.tx_ready), 32'd1);
         end
         check("brk_no_done", 32'(brk_done), 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
